quiz_sequencer: RTL

//  Game-side counterpart of the question ROM: issues question numbers on NUM_IN and

---
 rtl/quiz_sequencer.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/quiz_sequencer.sv
// Quiz game sequencer: fetches each question from the ROM, collects BCD key entry, judges and scores.
// Latency: START->ENTRY DB_LAT+2 cycles, ENTER->judge flag 2 cycles; no backpressure, keys outside ENTRY are dropped.
module quiz_sequencer #(
    parameter int NUM_Q       = 10,
    parameter int ANS_DIGITS  = 4,
    parameter int LVL_W       = 2,
    parameter int DB_LAT      = 1,
    parameter int TIME_LIMIT  = 1000,
    parameter int RESULT_HOLD = 50,
    localparam int ANS_W      = 4 * ANS_DIGITS
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    output logic [3:0]       NUM_IN,
    input  logic [35:0]      NUM_ARRAY,
    input  logic [ANS_W-1:0] ANSER,
    input  logic [LVL_W-1:0] LEVEL,
    input  logic             KEY_VALID,
    input  logic [3:0]       KEY_DIGIT,
    input  logic             KEY_CLR,
    input  logic             KEY_ENTER,
    output logic [35:0]      Q_ARRAY,
    output logic [LVL_W-1:0] Q_LEVEL,
    output logic [ANS_W-1:0] ENTRY_DISP,
    output logic             JUDGE_OK,
    output logic             JUDGE_NG,
    output logic [7:0]       SCORE,
    output logic             PLAYING,
    output logic             FINISH
);

    localparam int TMR_W  = $clog2(TIME_LIMIT + 1);
    localparam int HOLD_W = $clog2(RESULT_HOLD + 1);
    localparam int WAIT_W = $clog2(DB_LAT + 2);
    localparam int CNT_W  = $clog2(ANS_DIGITS + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_ENTRY  = 3'd2,
        S_JUDGE  = 3'd3,
        S_RESULT = 3'd4,
        S_FINISH = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         idx_q, idx_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [35:0]        q_array_q, q_array_d;
    logic [LVL_W-1:0]   q_level_q, q_level_d;
    logic [ANS_W-1:0]   ans_q, ans_d;
    logic [ANS_W-1:0]   entry_q, entry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               timeout_q, timeout_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic               ok_q, ok_d;
    logic               ng_q, ng_d;
    logic [7:0]         score_q, score_d;

    logic [8:0]         score_sum;
    logic               enter_ok;

    assign score_sum = {1'b0, score_q} + 9'(q_level_q) + 9'd1;
    assign enter_ok  = KEY_ENTER && (cnt_q != '0);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        wait_d    = wait_q;
        q_array_d = q_array_q;
        q_level_d = q_level_q;
        ans_d     = ans_q;
        entry_d   = entry_q;
        cnt_d     = cnt_q;
        timer_d   = timer_q;
        timeout_d = timeout_q;
        hold_d    = hold_q;
        ok_d      = ok_q;
        ng_d      = ng_q;
        score_d   = score_q;

        case (state_q)
            S_IDLE, S_FINISH: begin
                if (START) begin
                    idx_d   = '0;
                    score_d = '0;
                    wait_d  = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                // ROM answers the address DB_LAT edges after NUM_IN changed
                if (wait_q == WAIT_W'(DB_LAT)) begin
                    q_array_d = NUM_ARRAY;
                    q_level_d = LEVEL;
                    ans_d     = ANSER;
                    entry_d   = '0;
                    cnt_d     = '0;
                    timer_d   = '0;
                    timeout_d = 1'b0;
                    state_d   = S_ENTRY;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_ENTRY: begin
                timer_d = timer_q + 1'b1;
                if (KEY_ENTER) begin
                    if (enter_ok) begin
                        timeout_d = 1'b0;
                        state_d   = S_JUDGE;
                    end
                end else if (KEY_CLR) begin
                    entry_d = '0;
                    cnt_d   = '0;
                end else if (KEY_VALID && (KEY_DIGIT <= 4'd9)) begin
                    entry_d = {entry_q[ANS_W-5:0], KEY_DIGIT};
                    if (cnt_q != CNT_W'(ANS_DIGITS)) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                if (!enter_ok && (timer_q == TMR_W'(TIME_LIMIT - 1))) begin
                    timeout_d = 1'b1;
                    state_d   = S_JUDGE;
                end
            end
            S_JUDGE: begin
                if (!timeout_q && (entry_q == ans_q)) begin
                    ok_d    = 1'b1;
                    score_d = score_sum[8] ? 8'hFF : score_sum[7:0];
                end else begin
                    ng_d = 1'b1;
                end
                hold_d  = '0;
                state_d = S_RESULT;
            end
            S_RESULT: begin
                if (hold_q == HOLD_W'(RESULT_HOLD - 1)) begin
                    ok_d   = 1'b0;
                    ng_d   = 1'b0;
                    wait_d = '0;
                    if (idx_q == 4'(NUM_Q - 1)) begin
                        state_d = S_FINISH;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_FETCH;
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            wait_q    <= '0;
            q_array_q <= '0;
            q_level_q <= '0;
            ans_q     <= '0;
            entry_q   <= '0;
            cnt_q     <= '0;
            timer_q   <= '0;
            timeout_q <= 1'b0;
            hold_q    <= '0;
            ok_q      <= 1'b0;
            ng_q      <= 1'b0;
            score_q   <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            wait_q    <= wait_d;
            q_array_q <= q_array_d;
            q_level_q <= q_level_d;
            ans_q     <= ans_d;
            entry_q   <= entry_d;
            cnt_q     <= cnt_d;
            timer_q   <= timer_d;
            timeout_q <= timeout_d;
            hold_q    <= hold_d;
            ok_q      <= ok_d;
            ng_q      <= ng_d;
            score_q   <= score_d;
        end
    end

    assign NUM_IN     = idx_q;
    assign Q_ARRAY    = q_array_q;
    assign Q_LEVEL    = q_level_q;
    assign ENTRY_DISP = entry_q;
    assign JUDGE_OK   = ok_q;
    assign JUDGE_NG   = ng_q;
    assign SCORE      = score_q;
    assign PLAYING    = (state_q == S_FETCH) || (state_q == S_ENTRY) ||
                        (state_q == S_JUDGE) || (state_q == S_RESULT);
    assign FINISH     = (state_q == S_FINISH);

endmodule
